sparse_varray: RTL and testbench
================================

SPARSE_VARRAY -- requirements
Module: sparse_varray

Interface
REQ-001 Parameter ELEM_WIDTH, default 18, width of one stored element.
REQ-002 Parameter ADDR_BITS, default 16, virtual address width.
REQ-003 Parameter LOG_DEPTH, default 6, log2 of entry-queue depth (DEPTH = 2**LOG_DEPTH).
REQ-004 Parameter LEN_BITS, default 5, width of the run-length field.
REQ-005 One clock; reset is synchronous and active-high; ports are named clk and reset.
REQ-006 clk  in  1  clock; reset  in  1  synchronous active-high reset.
REQ-007 flush  in  1  discards all queued entries; varray_len is kept.
REQ-008 we  in  1  write request; w_ready  out  1  queue can accept a write (= !full).
REQ-009 write_addr  in  ADDR_BITS  first virtual address of the run; write_len  in  LEN_BITS  run length.
REQ-010 dat_w  in  ELEM_WIDTH  value for every address in [write_addr, write_addr+write_len).
REQ-011 re  in  1  read request; read_addr  in  ADDR_BITS  virtual address to read.
REQ-012 dat_r  out  ELEM_WIDTH  combinational read data; hit  out  1  combinational read-hit flag.
REQ-013 varray_len  out  ADDR_BITS+1  one past the highest written address.
REQ-014 count  out  LOG_DEPTH+1  occupied entries; full / empty  out  1 each.
REQ-015 is_new_superscalar_group  out  1  registered group-boundary flag.
REQ-016 err  out  1  sticky protocol-violation flag.

Function
REQ-017 Write accepted iff we && w_ready && write_len != 0 && write_addr >= varray_len; accepted entry {write_addr, write_len, dat_w} goes to the head entry, head advances modulo DEPTH.
REQ-018 On an accepted write, varray_len <= write_addr + write_len, computed at ADDR_BITS+1 bits with no wrap.
REQ-019 Write with we=1 and either write_len==0 or write_addr<varray_len is dropped and sets err; we while full is held off (no err).
REQ-020 hit = re && !empty && start[tail] <= read_addr < start[tail]+len[tail]; dat_r = hit ? data[tail] : 0; zero-cycle latency.
REQ-021 Entry retires (tail advances) when hit && read_addr == start[tail]+len[tail]-1.
REQ-022 re && read_addr >= varray_len sets err; hit stays 0.
REQ-023 count is exact over 0..DEPTH (no head/tail ambiguity); full = (count==DEPTH), empty = (count==0).
REQ-024 Accepted write and retire in the same cycle leave count unchanged; both pointers advance.
REQ-025 No bypass: a write in cycle N is readable no earlier than cycle N+1.
REQ-026 w_ready depends only on registered count; a retire while full does not enable a write in the same cycle.
REQ-027 is_new_superscalar_group: on re, next value is 1 if the entry retires or hit==0, else 0; held when re=0.
REQ-028 flush: head, tail, count <= 0 and is_new_superscalar_group <= 1; varray_len and err kept; a write in the flush cycle is discarded.

Reset
REQ-029 reset overrides flush and all requests; after reset: head=tail=count=0, varray_len=0, err=0, is_new_superscalar_group=1, empty=1, full=0, w_ready=1.
REQ-030 Entry storage is not reset; no output may depend on an unwritten entry (hit masks on !empty).

Structure
REQ-031 Package varray_pkg holds the default ELEM_WIDTH/ADDR_BITS/LEN_BITS/LOG_DEPTH constants and the entry struct typedef {start, len, data}.
REQ-032 Storage is the sub-module varray_entry_ram (1 write port, 1 asynchronous read port at tail); pointers, counters, flags and error logic stay in sparse_varray.

Verification (LOG_DEPTH=2)
REQ-033 Write {addr 0, len 3, D=0x11}; read 0,1,2 -> hit=1, dat_r=0x11 each; tail advances after addr 2; group flag 0,0,1.
REQ-034 Write {0,2,A}, {5,1,B}; read 3 -> hit=0, dat_r=0, group flag 1; read 5 -> B, retire, empty=1.
REQ-035 Four writes -> full=1, w_ready=0; 5th we ignored, err=0; retire one -> w_ready=1 next cycle.
REQ-036 Write {10,2}, then {11,1} -> second dropped, err=1, varray_len=12; write len 0 -> dropped, err=1.
REQ-037 Full queue, same-cycle retire and we -> write not accepted; not full, same-cycle write and retire -> count unchanged.
REQ-038 Flush with 3 entries -> count=0, varray_len unchanged; reset during flush -> varray_len=0, err=0.

Source files
------------

// File: rtl/sparse_varray_pkg.sv
// varray_pkg: shared constants and the queued-entry layout for sparse_varray.
// The defaults are the parameter defaults of the top level. entry_t describes
// one queued run {start, len, data} at those default widths.
package varray_pkg;

   localparam int ELEM_WIDTH_DEF = 18;
   localparam int ADDR_BITS_DEF  = 16;
   localparam int LEN_BITS_DEF   = 5;
   localparam int LOG_DEPTH_DEF  = 6;

   typedef struct packed {
      logic [ADDR_BITS_DEF-1:0]  start;
      logic [LEN_BITS_DEF-1:0]   len;
      logic [ELEM_WIDTH_DEF-1:0] data;
   } entry_t;

endpackage

// File: rtl/sparse_varray_if.sv
// varray_if: write/read/status bundle of sparse_varray.
//   master: drives flush, we, write_addr, write_len, dat_w, re, read_addr
//   slave : drives w_ready, dat_r, hit, varray_len, count, full, empty,
//           is_new_superscalar_group, err
interface varray_if
   import varray_pkg::*;
#(
   parameter int ELEM_WIDTH = ELEM_WIDTH_DEF,
   parameter int ADDR_BITS  = ADDR_BITS_DEF,
   parameter int LOG_DEPTH  = LOG_DEPTH_DEF,
   parameter int LEN_BITS   = LEN_BITS_DEF
);
   logic                  flush;
   logic                  we;
   logic                  w_ready;
   logic [ADDR_BITS-1:0]  write_addr;
   logic [LEN_BITS-1:0]   write_len;
   logic [ELEM_WIDTH-1:0] dat_w;
   logic                  re;
   logic [ADDR_BITS-1:0]  read_addr;
   logic [ELEM_WIDTH-1:0] dat_r;
   logic                  hit;
   logic [ADDR_BITS:0]    varray_len;
   logic [LOG_DEPTH:0]    count;
   logic                  full;
   logic                  empty;
   logic                  is_new_superscalar_group;
   logic                  err;

   modport master (
      output flush, we, write_addr, write_len, dat_w, re, read_addr,
      input  w_ready, dat_r, hit, varray_len, count, full, empty,
             is_new_superscalar_group, err
   );

   modport slave (
      input  flush, we, write_addr, write_len, dat_w, re, read_addr,
      output w_ready, dat_r, hit, varray_len, count, full, empty,
             is_new_superscalar_group, err
   );
endinterface

// File: rtl/sparse_varray_entry_ram.sv
// varray_entry_ram: entry storage for sparse_varray.
// One synchronous write port, one asynchronous read port (used at the tail).
// Contents are not reset; the owner masks reads of unwritten slots.
//   clk_i   : clock
//   we_i    : write enable
//   waddr_i : write slot, wdata_i : packed entry
//   raddr_i : read slot,  rdata_o : packed entry (combinational)
module varray_entry_ram #(
   parameter int WIDTH     = 39,
   parameter int LOG_DEPTH = 6
) (
   input  logic                 clk_i,
   input  logic                 we_i,
   input  logic [LOG_DEPTH-1:0] waddr_i,
   input  logic [WIDTH-1:0]     wdata_i,
   input  logic [LOG_DEPTH-1:0] raddr_i,
   output logic [WIDTH-1:0]     rdata_o
);
   logic [WIDTH-1:0] mem_q [2**LOG_DEPTH];

   always_ff @(posedge clk_i) begin
      if (we_i) begin
         mem_q[waddr_i] <= wdata_i;
      end
   end

   assign rdata_o = mem_q[raddr_i];
endmodule

// File: rtl/sparse_varray.sv
// sparse_varray: queue of {start, len, data} runs over a growing virtual array.
// Writes append a run whose start must lie at or beyond varray_len; reads are
// served only from the oldest run and retire it when its last address is read.
//   clk, reset : clock and synchronous active-high reset
//   bus        : varray_if slave (write/read requests, read data, status, err)
module sparse_varray
   import varray_pkg::*;
#(
   parameter int ELEM_WIDTH = ELEM_WIDTH_DEF,
   parameter int ADDR_BITS  = ADDR_BITS_DEF,
   parameter int LOG_DEPTH  = LOG_DEPTH_DEF,
   parameter int LEN_BITS   = LEN_BITS_DEF
) (
   input  logic   clk,
   input  logic   reset,
   varray_if.slave bus
);
   localparam int ENTRY_W = ADDR_BITS + LEN_BITS + ELEM_WIDTH;
   localparam logic [LOG_DEPTH:0]   DEPTH_C  = {1'b1, {LOG_DEPTH{1'b0}}};
   localparam logic [LOG_DEPTH:0]   CNT_ONE  = {{LOG_DEPTH{1'b0}}, 1'b1};
   localparam logic [LOG_DEPTH-1:0] PTR_ONE  = {{(LOG_DEPTH-1){1'b0}}, 1'b1};
   localparam logic [ADDR_BITS:0]   ADDR_ONE = {{ADDR_BITS{1'b0}}, 1'b1};

   logic [LOG_DEPTH-1:0] head_q, head_d, tail_q, tail_d;
   logic [LOG_DEPTH:0]   count_q, count_d;
   logic [ADDR_BITS:0]   vlen_q, vlen_d;
   logic                 err_q, err_d;
   logic                 grp_q, grp_d;

   logic [ENTRY_W-1:0]    tail_entry;
   logic [ADDR_BITS-1:0]  t_start;
   logic [LEN_BITS-1:0]   t_len;
   logic [ELEM_WIDTH-1:0] t_data;
   logic [ADDR_BITS:0]    t_end, t_last, rd_ext, wr_ext, wr_end;

   logic full, empty, hit, retire, wr_acc, wr_bad, rd_bad;

   varray_entry_ram #(
      .WIDTH     (ENTRY_W),
      .LOG_DEPTH (LOG_DEPTH)
   ) u_ram (
      .clk_i   (clk),
      .we_i    (wr_acc),
      .waddr_i (head_q),
      .wdata_i ({bus.write_addr, bus.write_len, bus.dat_w}),
      .raddr_i (tail_q),
      .rdata_o (tail_entry)
   );

   assign {t_start, t_len, t_data} = tail_entry;

   // Address arithmetic one bit wider than the address so runs ending at the
   // top of the address space do not wrap.
   assign t_end  = {1'b0, t_start} + {{(ADDR_BITS+1-LEN_BITS){1'b0}}, t_len};
   assign t_last = t_end - ADDR_ONE;
   assign rd_ext = {1'b0, bus.read_addr};
   assign wr_ext = {1'b0, bus.write_addr};
   assign wr_end = wr_ext + {{(ADDR_BITS+1-LEN_BITS){1'b0}}, bus.write_len};

   assign full  = (count_q == DEPTH_C);
   assign empty = (count_q == '0);

   // An empty queue masks the tail slot, which may never have been written.
   assign hit    = bus.re && !empty && (rd_ext >= {1'b0, t_start}) && (rd_ext < t_end);
   assign retire = hit && (rd_ext == t_last);

   // Write acceptance looks only at the registered count, so a retire while
   // full cannot open a slot for a write in the same cycle.
   assign wr_acc = bus.we && !full && !bus.flush && (bus.write_len != '0) && (wr_ext >= vlen_q);
   assign wr_bad = bus.we && !full && !bus.flush && ((bus.write_len == '0) || (wr_ext < vlen_q));
   assign rd_bad = bus.re && !bus.flush && (rd_ext >= vlen_q);

   always_comb begin
      head_d  = head_q;
      tail_d  = tail_q;
      count_d = count_q;
      vlen_d  = vlen_q;
      err_d   = err_q | wr_bad | rd_bad;
      grp_d   = grp_q;
      if (bus.flush) begin
         head_d  = '0;
         tail_d  = '0;
         count_d = '0;
         grp_d   = 1'b1;
      end else begin
         if (wr_acc) begin
            head_d = head_q + PTR_ONE;
            vlen_d = wr_end;
         end
         if (retire) begin
            tail_d = tail_q + PTR_ONE;
         end
         case ({wr_acc, retire})
            2'b10:   count_d = count_q + CNT_ONE;
            2'b01:   count_d = count_q - CNT_ONE;
            default: count_d = count_q;
         endcase
         if (bus.re) begin
            grp_d = retire || !hit;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         head_q  <= '0;
         tail_q  <= '0;
         count_q <= '0;
         vlen_q  <= '0;
         err_q   <= 1'b0;
         grp_q   <= 1'b1;
      end else begin
         head_q  <= head_d;
         tail_q  <= tail_d;
         count_q <= count_d;
         vlen_q  <= vlen_d;
         err_q   <= err_d;
         grp_q   <= grp_d;
      end
   end

   assign bus.w_ready                  = !full;
   assign bus.dat_r                    = hit ? t_data : '0;
   assign bus.hit                      = hit;
   assign bus.varray_len               = vlen_q;
   assign bus.count                    = count_q;
   assign bus.full                     = full;
   assign bus.empty                    = empty;
   assign bus.is_new_superscalar_group = grp_q;
   assign bus.err                      = err_q;
endmodule

// File: tb/tb_sparse_varray.sv
// tb_sparse_varray: directed stimulus for sparse_varray (LOG_DEPTH=2) with a
// queue-based reference model compared on every falling edge, plus literal
// expectations at the key points of each scenario.
module tb_sparse_varray;
   import varray_pkg::*;

   localparam int EW = 18;
   localparam int AB = 16;
   localparam int LD = 2;
   localparam int LB = 5;
   localparam int DEPTH = 4;

   logic clk;
   logic reset;
   int   checks = 0;
   int   errors = 0;

   varray_if #(.ELEM_WIDTH(EW), .ADDR_BITS(AB), .LOG_DEPTH(LD), .LEN_BITS(LB)) bus ();

   sparse_varray #(.ELEM_WIDTH(EW), .ADDR_BITS(AB), .LOG_DEPTH(LD), .LEN_BITS(LB)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   // ---------------- reference model ----------------
   entry_t m_q[$];
   int     m_vlen = 0;
   bit     m_err  = 0;
   bit     m_grp  = 1;
   bit     m_valid = 0;

   always @(negedge clk) begin
      bit ehit, ret, acc, fullm;
      int ed, rd, wa, wl;
      rd = int'(bus.read_addr);
      wa = int'(bus.write_addr);
      wl = int'(bus.write_len);
      ehit = 0;
      ed   = 0;
      ret  = 0;
      if (bus.re && m_q.size() > 0) begin
         if (rd >= int'(m_q[0].start) && rd < int'(m_q[0].start) + int'(m_q[0].len)) begin
            ehit = 1;
            ed   = int'(m_q[0].data);
            ret  = (rd == int'(m_q[0].start) + int'(m_q[0].len) - 1);
         end
      end
      if (m_valid) begin
         check("mon_hit",     32'(bus.hit),        32'(ehit));
         check("mon_dat_r",   32'(bus.dat_r),      32'(ed));
         check("mon_count",   32'(bus.count),      32'(m_q.size()));
         check("mon_full",    32'(bus.full),       32'(m_q.size() == DEPTH));
         check("mon_empty",   32'(bus.empty),      32'(m_q.size() == 0));
         check("mon_w_ready", 32'(bus.w_ready),    32'(m_q.size() != DEPTH));
         check("mon_vlen",    32'(bus.varray_len), 32'(m_vlen));
         check("mon_err",     32'(bus.err),        32'(m_err));
         check("mon_group",   32'(bus.is_new_superscalar_group), 32'(m_grp));
      end
      // state update for the coming rising edge
      if (reset) begin
         m_q.delete();
         m_vlen  = 0;
         m_err   = 0;
         m_grp   = 1;
         m_valid = 1;
      end else if (bus.flush) begin
         m_q.delete();
         m_grp = 1;
      end else begin
         fullm = (m_q.size() == DEPTH);
         acc   = bus.we && !fullm && wl != 0 && wa >= m_vlen;
         if (bus.we && !fullm && !acc) m_err = 1;
         if (bus.re && rd >= m_vlen) m_err = 1;
         if (bus.re) m_grp = ret || !ehit;
         if (ret) void'(m_q.pop_front());
         if (acc) begin
            m_q.push_back('{start: bus.write_addr, len: bus.write_len, data: bus.dat_w});
            m_vlen = wa + wl;
         end
      end
   end

   // ---------------- stimulus helpers ----------------
   // drive(): apply one cycle of inputs and settle mid-cycle; fin(): clock it.
   task automatic drive(input bit w, input int wa, input int wl, input int dw,
                        input bit r, input int ra, input bit fl);
      bus.we         = w;
      bus.write_addr = AB'(wa);
      bus.write_len  = LB'(wl);
      bus.dat_w      = EW'(dw);
      bus.re         = r;
      bus.read_addr  = AB'(ra);
      bus.flush      = fl;
      #2;
      $display("t=%0t we=%0b wa=%0d wl=%0d dw=0x%0h re=%0b ra=%0d flush=%0b -> hit=%0b dat_r=0x%0h count=%0d",
               $time, w, wa, wl, dw, r, ra, fl, bus.hit, bus.dat_r, bus.count);
   endtask

   task automatic fin();
      @(posedge clk);
      #1;
      bus.we    = 0;
      bus.re    = 0;
      bus.flush = 0;
   endtask

   task automatic wr(input int wa, input int wl, input int dw);
      drive(1, wa, wl, dw, 0, 0, 0);
      fin();
   endtask

   task automatic rd_chk(input string name, input int ra, input bit eh, input int ed);
      drive(0, 0, 0, 0, 1, ra, 0);
      check({name, "_hit"}, 32'(bus.hit), 32'(eh));
      check({name, "_dat"}, 32'(bus.dat_r), 32'(ed));
      fin();
   endtask

   task automatic do_reset();
      reset = 1;
      @(posedge clk); #1;
      @(posedge clk); #1;
      reset = 0;
      $display("t=%0t reset released", $time);
   endtask

   initial begin
      reset = 1;
      bus.flush = 0; bus.we = 0; bus.re = 0;
      bus.write_addr = '0; bus.write_len = '0; bus.dat_w = '0; bus.read_addr = '0;
      do_reset();
      check("rst_count",   32'(bus.count), 0);
      check("rst_empty",   32'(bus.empty), 1);
      check("rst_full",    32'(bus.full), 0);
      check("rst_w_ready", 32'(bus.w_ready), 1);
      check("rst_vlen",    32'(bus.varray_len), 0);
      check("rst_err",     32'(bus.err), 0);
      check("rst_group",   32'(bus.is_new_superscalar_group), 1);

      // single run of three elements
      wr(0, 3, 'h11);
      check("s1_vlen", 32'(bus.varray_len), 3);
      rd_chk("s1_r0", 0, 1, 'h11);
      check("s1_grp0", 32'(bus.is_new_superscalar_group), 0);
      rd_chk("s1_r1", 1, 1, 'h11);
      check("s1_grp1", 32'(bus.is_new_superscalar_group), 0);
      rd_chk("s1_r2", 2, 1, 'h11);
      check("s1_grp2", 32'(bus.is_new_superscalar_group), 1);
      check("s1_empty", 32'(bus.empty), 1);
      // no bypass: write and read of the queue in the same cycle
      drive(1, 3, 2, 'h22, 1, 1, 0);
      check("s1_nobypass", 32'(bus.hit), 0);
      fin();
      rd_chk("s1_r3", 3, 1, 'h22);

      // miss then hit on the second run
      do_reset();
      wr(0, 2, 'h0A);
      wr(5, 1, 'h0B);
      check("s2_vlen", 32'(bus.varray_len), 6);
      rd_chk("s2_r0", 0, 1, 'h0A);
      rd_chk("s2_r1", 1, 1, 'h0A);
      rd_chk("s2_r3", 3, 0, 0);
      check("s2_grp_miss", 32'(bus.is_new_superscalar_group), 1);
      rd_chk("s2_r5", 5, 1, 'h0B);
      check("s2_empty", 32'(bus.empty), 1);
      check("s2_err", 32'(bus.err), 0);

      // fill to full
      do_reset();
      for (int i = 0; i < 4; i++) wr(i, 1, i + 1);
      check("s3_full", 32'(bus.full), 1);
      check("s3_w_ready", 32'(bus.w_ready), 0);
      wr(4, 1, 5);
      check("s3_held_count", 32'(bus.count), 4);
      check("s3_held_err", 32'(bus.err), 0);
      drive(0, 0, 0, 0, 1, 0, 0);
      check("s3_ret_wready_same", 32'(bus.w_ready), 0);
      fin();
      check("s3_ret_wready_next", 32'(bus.w_ready), 1);
      // simultaneous write and retire with room
      drive(1, 4, 1, 5, 1, 1, 0);
      check("s4_ret_hit", 32'(bus.hit), 1);
      fin();
      check("s4_count_same", 32'(bus.count), 3);
      wr(5, 1, 6);
      check("s4_full", 32'(bus.full), 1);
      // retire while full: the write must not be taken
      drive(1, 6, 1, 7, 1, 2, 0);
      fin();
      check("s4_count_after", 32'(bus.count), 3);
      check("s4_vlen_after", 32'(bus.varray_len), 6);
      check("s4_err_after", 32'(bus.err), 0);
      rd_chk("s4_r3", 3, 1, 4);

      // protocol violations
      do_reset();
      wr(10, 2, 'h33);
      wr(11, 1, 'h44);
      check("s5_overlap_err", 32'(bus.err), 1);
      check("s5_overlap_vlen", 32'(bus.varray_len), 12);
      check("s5_overlap_count", 32'(bus.count), 1);
      do_reset();
      wr(0, 0, 'h55);
      check("s5_len0_err", 32'(bus.err), 1);
      check("s5_len0_count", 32'(bus.count), 0);
      do_reset();
      rd_chk("s5_oob", 0, 0, 0);
      check("s5_oob_err", 32'(bus.err), 1);

      // run ending at the top of the address space
      do_reset();
      wr('hFFFF, 1, 'h66);
      check("s7_vlen_top", 32'(bus.varray_len), 'h10000);
      rd_chk("s7_rtop", 'hFFFF, 1, 'h66);
      wr(0, 1, 'h77);
      check("s7_after_top_err", 32'(bus.err), 1);

      // flush keeps varray_len and err
      do_reset();
      wr(0, 2, 1);
      wr(2, 1, 2);
      wr(3, 1, 3);
      wr(0, 0, 0);
      rd_chk("s6_r0", 0, 1, 1);
      check("s6_grp_before", 32'(bus.is_new_superscalar_group), 0);
      drive(1, 4, 1, 4, 0, 0, 1);
      fin();
      check("s6_flush_count", 32'(bus.count), 0);
      check("s6_flush_vlen", 32'(bus.varray_len), 4);
      check("s6_flush_err", 32'(bus.err), 1);
      check("s6_flush_grp", 32'(bus.is_new_superscalar_group), 1);
      wr(4, 1, 9);
      rd_chk("s6_r4", 4, 1, 9);
      bus.flush = 1;
      do_reset();
      bus.flush = 0;
      check("s6_rst_vlen", 32'(bus.varray_len), 0);
      check("s6_rst_err", 32'(bus.err), 0);

      @(posedge clk); #1;
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
